commit_trace_buffer: RTL and testbench

//  Synthesizable, parametrised successor to the simulation-only commit monitor.
//  - Samples the CPU commit-side signals every cycle: reg write, mem read/write, halt.
//  - Packs each active cycle into one record and buffers it in a FWFT FIFO.
//  - Drains records over a valid/ready port.
//  - Keeps cycle and instruction counters, a cycle watchdog and drop accounting.
//  - Sits beside the cpu top level; usable in sim and on FPGA.

---
 rtl/commit_trace_buffer.sv | 101 ++++++++++
 tb/tb_commit_trace_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: packs CPU commit activity into records and drains them through a FWFT FIFO
module commit_trace_buffer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              reg_we_i,
  input  logic [REG_W-1:0]  reg_dst_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              halt_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_flags,
  output logic [ADDR_W-1:0] out_pc,
  output logic [REG_W-1:0]  out_reg,
  output logic [DATA_W-1:0] out_rdata,
  output logic [ADDR_W-1:0] out_maddr,
  output logic [DATA_W-1:0] out_mdata,
  output logic [CNT_W-1:0]  out_cycle,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 5 + 2*ADDR_W + REG_W + 2*DATA_W + CNT_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, stateNext;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rec, head;
  logic [AW:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] cycleNext;
  logic [4:0] flags;
  logic empty, full, push, pop, accept, wdogHit, running;
  assign running   = state == RUN;
  assign cycleNext = cycle_count + 1'b1;
  assign wdogHit   = running && cycleNext == CNT_W'(WDOG_LIMIT);
  assign empty     = wrPtr == rdPtr;
  assign full      = wrPtr[AW] != rdPtr[AW] && wrPtr[AW-1:0] == rdPtr[AW-1:0];
  assign push      = running && (reg_we_i || mem_re_i || mem_we_i || halt_i || wdogHit);
  assign pop       = !empty && out_ready;
  assign accept    = push && (!full || pop);
  // a watchdog record carries only its own flag (plus halt if both coincide)
  assign flags = {wdogHit, halt_i, mem_we_i & ~wdogHit, mem_re_i & ~wdogHit, reg_we_i & ~wdogHit};
  assign rec   = {flags, pc_i, reg_dst_i, reg_data_i, mem_addr_i,
                  mem_we_i ? mem_wdata_i : mem_rdata_i, cycleNext};
  assign head  = empty ? '0 : mem[rdPtr[AW-1:0]];
  assign {out_flags, out_pc, out_reg, out_rdata, out_maddr, out_mdata, out_cycle} = head;
  assign out_valid = !empty;
  assign busy      = state == RUN || state == DRAIN;
  assign done      = state == DONE;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = en ? RUN : IDLE;
      RUN:     stateNext = (halt_i || wdogHit) ? DRAIN : RUN;
      DRAIN:   stateNext = empty ? DONE : DRAIN;
      default: stateNext = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wrPtr[AW-1:0]] <= rec;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wrPtr       <= '0;
      rdPtr       <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (running) begin
        cycle_count <= cycleNext;
        if (halt_i || reg_we_i || mem_we_i) inst_count <= inst_count + 1'b1;
        if (push && !accept) begin
          overflow <= 1'b1;
          if (!(&drop_count)) drop_count <= drop_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed checks of capture, FIFO drain, overflow, halt, watchdog and reset
module tb_commit_trace_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [15:0] pc_i = '0;
  logic reg_we_i = 1'b0;
  logic [3:0] reg_dst_i = '0;
  logic [15:0] reg_data_i = '0;
  logic mem_re_i = 1'b0;
  logic mem_we_i = 1'b0;
  logic [15:0] mem_addr_i = '0;
  logic [15:0] mem_wdata_i = '0;
  logic [15:0] mem_rdata_i = '0;
  logic halt_i = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, overflow, busy, done;
  logic [4:0] out_flags;
  logic [15:0] out_pc, out_rdata, out_maddr, out_mdata;
  logic [3:0] out_reg;
  logic [31:0] out_cycle, cycle_count, inst_count, drop_count;
  int passCount = 0;
  int checkCount = 0;

  commit_trace_buffer #(.DEPTH(16), .WDOG_LIMIT(50)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_i(pc_i), .reg_we_i(reg_we_i),
    .reg_dst_i(reg_dst_i), .reg_data_i(reg_data_i), .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_i(mem_rdata_i), .halt_i(halt_i), .out_valid(out_valid),
    .out_ready(out_ready), .out_flags(out_flags), .out_pc(out_pc), .out_reg(out_reg),
    .out_rdata(out_rdata), .out_maddr(out_maddr), .out_mdata(out_mdata),
    .out_cycle(out_cycle), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got t=%0t required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    en = 1'b0; pc_i = '0; reg_we_i = 1'b0; reg_dst_i = '0; reg_data_i = '0;
    mem_re_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    mem_rdata_i = '0; halt_i = 1'b0;
  endtask

  task automatic resetAndStart();
    clearInputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checkCount++;
    if ({out_valid, overflow, busy, done} !== 4'b0000)
      $display("FAIL reset_flags: got valid/ovf/busy/done=%b required 0000", {out_valid, overflow, busy, done});
    else passCount++;
    checkCount++;
    if ({cycle_count, inst_count, drop_count} !== 96'd0)
      $display("FAIL reset_counters: got cyc=%0d inst=%0d drop=%0d required 0 0 0", cycle_count, inst_count, drop_count);
    else passCount++;
    checkCount++;
    if ({out_flags, out_pc, out_cycle} !== 53'd0)
      $display("FAIL reset_data: got flags=%b pc=%h cyc=%0d required zeros", out_flags, out_pc, out_cycle);
    else passCount++;
    tick();
    checkCount++;
    if (busy !== 1'b0)
      $display("FAIL idle_without_en: got busy=%b required 0", busy);
    else passCount++;
  endtask

  task automatic test_basic();
    resetAndStart();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      reg_we_i = 1'b1;
      reg_dst_i = 4'(i);
      reg_data_i = 16'(i);
      pc_i = 16'h0100 + 16'(4 * i);
      tick();
      checkCount++;
      if ({out_valid, out_reg, out_rdata, out_cycle, out_flags} !== {1'b1, 4'(i), 16'(i), 32'(i), 5'b00001})
        $display("FAIL basic_rec%0d: got v=%b reg=%0d data=%h cyc=%0d flags=%b required 1 %0d %h %0d 00001",
                 i, out_valid, out_reg, out_rdata, out_cycle, out_flags, i, i, i);
      else passCount++;
    end
    clearInputs();
    tick();
    checkCount++;
    if ({out_valid, inst_count, cycle_count, busy} !== {1'b0, 32'd3, 32'd4, 1'b1})
      $display("FAIL basic_after: got v=%b inst=%0d cyc=%0d busy=%b required 0 3 4 1",
               out_valid, inst_count, cycle_count, busy);
    else passCount++;
  endtask

  task automatic test_load();
    reg_we_i = 1'b1; mem_re_i = 1'b1; reg_dst_i = 4'd5; reg_data_i = 16'hBEEF;
    mem_addr_i = 16'h0040; mem_rdata_i = 16'hBEEF; mem_wdata_i = 16'h1234;
    tick();
    clearInputs();
    checkCount++;
    if ({out_flags, out_mdata, out_maddr, out_cycle} !== {5'b00011, 16'hBEEF, 16'h0040, 32'd5})
      $display("FAIL load_rec: got flags=%b mdata=%h maddr=%h cyc=%0d required 00011 beef 0040 5",
               out_flags, out_mdata, out_maddr, out_cycle);
    else passCount++;
    checkCount++;
    if (inst_count !== 32'd4)
      $display("FAIL load_inst: got %0d required 4", inst_count);
    else passCount++;
    tick();
  endtask

  task automatic test_overflow();
    resetAndStart();
    for (int i = 0; i < 20; i++) begin
      mem_we_i = 1'b1;
      mem_addr_i = 16'(i);
      mem_wdata_i = 16'h1000 + 16'(i);
      mem_rdata_i = 16'hDEAD;
      tick();
    end
    clearInputs();
    checkCount++;
    if ({drop_count, overflow, inst_count} !== {32'd4, 1'b1, 32'd20})
      $display("FAIL ovf_counts: got drop=%0d ovf=%b inst=%0d required 4 1 20", drop_count, overflow, inst_count);
    else passCount++;
    tick();
    tick();
    checkCount++;
    if ({out_valid, out_flags, out_mdata, out_cycle} !== {1'b1, 5'b00100, 16'h1000, 32'd1})
      $display("FAIL ovf_hold: got v=%b flags=%b mdata=%h cyc=%0d required 1 00100 1000 1",
               out_valid, out_flags, out_mdata, out_cycle);
    else passCount++;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkCount++;
      if ({out_valid, out_mdata, out_maddr, out_cycle} !== {1'b1, 16'h1000 + 16'(k), 16'(k), 32'(k + 1)})
        $display("FAIL ovf_pop%0d: got v=%b mdata=%h maddr=%h cyc=%0d required 1 %h %h %0d",
                 k, out_valid, out_mdata, out_maddr, out_cycle, 16'h1000 + 16'(k), k, k + 1);
      else passCount++;
      tick();
    end
    checkCount++;
    if ({out_valid, drop_count} !== {1'b0, 32'd4})
      $display("FAIL ovf_empty: got v=%b drop=%0d required 0 4", out_valid, drop_count);
    else passCount++;
  endtask

  task automatic test_halt();
    resetAndStart();
    for (int i = 1; i <= 7; i++) begin
      clearInputs();
      reg_we_i = (i == 2 || i == 4);
      reg_dst_i = 4'(i);
      halt_i = (i == 7);
      pc_i = 16'h0200 + 16'(i);
      tick();
    end
    clearInputs();
    checkCount++;
    if ({busy, done, cycle_count, inst_count} !== {1'b1, 1'b0, 32'd7, 32'd3})
      $display("FAIL halt_enter: got busy=%b done=%b cyc=%0d inst=%0d required 1 0 7 3",
               busy, done, cycle_count, inst_count);
    else passCount++;
    reg_we_i = 1'b1;
    mem_we_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clearInputs();
    checkCount++;
    if ({busy, done, cycle_count, inst_count, out_cycle} !== {1'b1, 1'b0, 32'd7, 32'd3, 32'd2})
      $display("FAIL halt_frozen: got busy=%b done=%b cyc=%0d inst=%0d head=%0d required 1 0 7 3 2",
               busy, done, cycle_count, inst_count, out_cycle);
    else passCount++;
    out_ready = 1'b1;
    tick();
    tick();
    checkCount++;
    if ({out_flags, out_pc, out_cycle} !== {5'b01000, 16'h0207, 32'd7})
      $display("FAIL halt_rec: got flags=%b pc=%h cyc=%0d required 01000 0207 7", out_flags, out_pc, out_cycle);
    else passCount++;
    tick();
    checkCount++;
    if ({out_valid, busy, done} !== 3'b010)
      $display("FAIL halt_lastpop: got v/busy/done=%b required 010", {out_valid, busy, done});
    else passCount++;
    tick();
    checkCount++;
    if ({busy, done} !== 2'b01)
      $display("FAIL halt_done: got busy/done=%b required 01", {busy, done});
    else passCount++;
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    checkCount++;
    if ({done, cycle_count} !== {1'b1, 32'd7})
      $display("FAIL halt_hold: got done=%b cyc=%0d required 1 7", done, cycle_count);
    else passCount++;
  endtask

  task automatic test_wdog();
    resetAndStart();
    out_ready = 1'b1;
    pc_i = 16'hABCD;
    for (int i = 0; i < 49; i++) tick();
    checkCount++;
    if ({out_valid, busy, cycle_count} !== {1'b0, 1'b1, 32'd49})
      $display("FAIL wdog_pre: got v=%b busy=%b cyc=%0d required 0 1 49", out_valid, busy, cycle_count);
    else passCount++;
    tick();
    checkCount++;
    if ({out_valid, out_flags, out_cycle, out_pc, cycle_count} !== {1'b1, 5'b10000, 32'd50, 16'hABCD, 32'd50})
      $display("FAIL wdog_rec: got v=%b flags=%b cyc=%0d pc=%h count=%0d required 1 10000 50 abcd 50",
               out_valid, out_flags, out_cycle, out_pc, cycle_count);
    else passCount++;
    tick();
    checkCount++;
    if ({out_valid, busy, done} !== 3'b010)
      $display("FAIL wdog_drain: got v/busy/done=%b required 010", {out_valid, busy, done});
    else passCount++;
    tick();
    checkCount++;
    if ({busy, done, cycle_count} !== {2'b01, 32'd50})
      $display("FAIL wdog_done: got busy/done=%b cyc=%0d required 01 50", {busy, done}, cycle_count);
    else passCount++;
  endtask

  task automatic test_midreset();
    resetAndStart();
    for (int i = 1; i <= 5; i++) begin
      reg_we_i = 1'b1;
      reg_dst_i = 4'(i);
      tick();
    end
    checkCount++;
    if ({out_valid, inst_count} !== {1'b1, 32'd5})
      $display("FAIL mid_pre: got v=%b inst=%0d required 1 5", out_valid, inst_count);
    else passCount++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clearInputs();
    checkCount++;
    if ({out_valid, busy, done, overflow, cycle_count, inst_count, drop_count, out_cycle} !== 132'd0)
      $display("FAIL mid_reset: got v=%b busy=%b cyc=%0d inst=%0d drop=%0d head=%0d required all 0",
               out_valid, busy, cycle_count, inst_count, drop_count, out_cycle);
    else passCount++;
    en = 1'b1;
    tick();
    clearInputs();
    reg_we_i = 1'b1;
    reg_dst_i = 4'd9;
    tick();
    clearInputs();
    checkCount++;
    if ({out_valid, out_reg, out_cycle} !== {1'b1, 4'd9, 32'd1})
      $display("FAIL mid_restart: got v=%b reg=%0d cyc=%0d required 1 9 1", out_valid, out_reg, out_cycle);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_overflow();
    test_halt();
    test_wdog();
    test_midreset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
